bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 139 +++++++++++++
 tb/tb_bit_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a 2-entry holding FIFO. Words stream out back to back on w
// when the buffer keeps up, with a one-cycle frame_done pulse marking each word's last bit.
module bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             w,
   output logic             w_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             w_q, w_d;
   logic             wv_q, wv_d;
   logic             fd_q, fd_d;

   logic [WIDTH-1:0] buf_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       count_q, count_d;

   logic             push, pop;
   logic [WIDTH-1:0] head;
   logic             ld_bit, sh_bit;
   logic [WIDTH-1:0] ld_sr, sh_sr;

   // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
   assign din_ready  = (count_q < 2'd2) && !Rst;
   assign push       = din_valid && din_ready;
   assign head       = buf_q[rd_ptr_q];
   assign w          = w_q;
   assign w_valid    = wv_q;
   assign frame_done = fd_q;
   assign busy       = (state_q == StShift) || (count_q != 2'd0);

   always_comb begin
      if (MSB_FIRST) begin
         ld_bit = head[WIDTH-1];
         ld_sr  = head << 1;
         sh_bit = sr_q[WIDTH-1];
         sh_sr  = sr_q << 1;
      end else begin
         ld_bit = head[0];
         ld_sr  = head >> 1;
         sh_bit = sr_q[0];
         sh_sr  = sr_q >> 1;
      end
   end

   // cnt_q counts bits still to come after the one currently on w.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      w_d     = w_q;
      wv_d    = wv_q;
      fd_d    = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            w_d  = IDLE_BIT;
            wv_d = 1'b0;
            pop  = (count_q != 2'd0);
         end
         StShift: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               sr_d  = sh_sr;
               w_d   = sh_bit;
               fd_d  = (cnt_q == CW'(1));
            end else if (count_q != 2'd0) begin
               pop = 1'b1;
            end else begin
               state_d = StIdle;
               w_d     = IDLE_BIT;
               wv_d    = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
      if (pop) begin
         state_d = StShift;
         cnt_d   = CW'(WIDTH - 1);
         sr_d    = ld_sr;
         w_d     = ld_bit;
         wv_d    = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sr_q     <= '0;
         w_q      <= IDLE_BIT;
         wv_q     <= 1'b0;
         fd_q     <= 1'b0;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         w_q     <= w_d;
         wv_q    <= wv_d;
         fd_q    <= fd_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) buf_q[wr_ptr_q] <= din;
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default MSB-first instance plus LSB-first and IDLE_BIT=1
// instances sharing the clock and reset.
module tb_bit_serializer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready, w, w_valid, busy, frame_done;

   logic [7:0] din_l = 8'h00;
   logic       din_valid_l = 1'b0;
   logic       din_ready_l, w_l, w_valid_l, busy_l, frame_done_l;

   logic       din_ready_i, w_i, w_valid_i, busy_i, frame_done_i;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  words [4];
   int          idx, nbits, nfd, bad_valid, bad_fd;
   logic        acc;
   logic [31:0] bits;
   logic [63:0] ready_hist;

   always #5 Clk = ~Clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .Clk(Clk), .Rst(Rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .w(w), .w_valid(w_valid), .busy(busy), .frame_done(frame_done)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .Clk(Clk), .Rst(Rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
      .w(w_l), .w_valid(w_valid_l), .busy(busy_l), .frame_done(frame_done_l)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_idle1 (
      .Clk(Clk), .Rst(Rst), .din(8'h00), .din_valid(1'b0), .din_ready(din_ready_i),
      .w(w_i), .w_valid(w_valid_i), .busy(busy_i), .frame_done(frame_done_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   // Checks n consecutive bits on the default instance, first bit = exp[n-1], one frame per 8.
   task automatic check_stream(input string tag, input logic [15:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("%s_bit%0d", tag, i), {30'd0, w_valid, w}, {30'd0, 1'b1, exp[n-1-i]});
         check_eq($sformatf("%s_fd%0d", tag, i), {31'd0, frame_done}, {31'd0, (i % 8) == 7});
         step();
      end
      check_eq({tag, "_end_valid"}, {31'd0, w_valid}, 32'd0);
      check_eq({tag, "_end_w"}, {31'd0, w}, 32'd0);
   endtask

   initial begin
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

      // Reset state
      step(); step();
      check_eq("rst_w_valid", {31'd0, w_valid}, 32'd0);
      check_eq("rst_w", {31'd0, w}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check_eq("rst_ready", {31'd0, din_ready}, 32'd0);
      check_eq("rst_idle1_w", {31'd0, w_i}, 32'd1);
      Rst = 1'b0;
      #1;
      check_eq("post_rst_ready", {31'd0, din_ready}, 32'd1);

      // Single word 0xA5, MSB first
      din = 8'hA5; din_valid = 1'b1;
      step();
      din_valid = 1'b0; din = 8'h00;
      check_eq("a5_lat_valid", {31'd0, w_valid}, 32'd0);
      check_eq("a5_lat_busy", {31'd0, busy}, 32'd1);
      step();
      check_stream("a5", 16'h00A5, 8);
      check_eq("a5_busy_after", {31'd0, busy}, 32'd0);

      // Back-to-back 0xFF, 0x00 with no gap
      din = 8'hFF; din_valid = 1'b1;
      step();
      din = 8'h00;
      step();
      din_valid = 1'b0;
      check_stream("ff00", 16'hFF00, 16);

      // Held din_valid: four words, back-pressure after two buffered
      idx = 0; nbits = 0; nfd = 0; bits = '0; ready_hist = '0;
      din = words[0]; din_valid = 1'b1;
      for (int c = 0; c < 60; c++) begin
         acc = din_valid && din_ready;
         step();
         if (acc) begin
            idx++;
            if (idx < 4) din = words[idx];
            else begin
               din_valid = 1'b0;
               din = 8'hEE;
            end
         end
         ready_hist[c] = din_ready;
         if (w_valid) begin
            bits = {bits[30:0], w};
            nbits++;
         end
         if (frame_done) nfd++;
      end
      check_eq("fill_accepted", idx, 32'd4);
      check_eq("fill_nbits", nbits, 32'd32);
      check_eq("fill_bits", bits, 32'h11223344);
      check_eq("fill_frames", nfd, 32'd4);
      check_eq("fill_ready_c2", {31'd0, ready_hist[2]}, 32'd0);
      check_eq("fill_ready_c8", {31'd0, ready_hist[8]}, 32'd0);
      check_eq("fill_ready_c9", {31'd0, ready_hist[9]}, 32'd1);
      check_eq("fill_ready_c10", {31'd0, ready_hist[10]}, 32'd0);
      check_eq("fill_busy_after", {31'd0, busy}, 32'd0);

      // LSB-first instance, 0x01 -> 1 then seven 0s
      din_l = 8'h01; din_valid_l = 1'b1;
      step();
      din_valid_l = 1'b0; din_l = 8'hFF;
      step();
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("lsb_bit%0d", i), {30'd0, w_valid_l, w_l}, {30'd0, 1'b1, i == 0});
         check_eq($sformatf("lsb_fd%0d", i), {31'd0, frame_done_l}, {31'd0, i == 7});
         step();
      end
      check_eq("lsb_end_valid", {31'd0, w_valid_l}, 32'd0);

      // Reset mid-frame during the 4th bit of 0xC3 with 0x5A buffered
      din = 8'hC3; din_valid = 1'b1;
      step();
      din = 8'h5A;
      step();
      din_valid = 1'b0;
      check_eq("c3_bit0", {31'd0, w}, 32'd1);
      step();
      check_eq("c3_bit1", {31'd0, w}, 32'd1);
      step();
      check_eq("c3_bit2", {31'd0, w}, 32'd0);
      step();
      check_eq("c3_bit3", {31'd0, w}, 32'd0);
      check_eq("c3_busy_pre", {31'd0, busy}, 32'd1);
      Rst = 1'b1;
      #1;
      check_eq("c3_ready_in_rst", {31'd0, din_ready}, 32'd0);
      step();
      Rst = 1'b0;
      #1;
      check_eq("c3_rst_valid", {31'd0, w_valid}, 32'd0);
      check_eq("c3_rst_w", {31'd0, w}, 32'd0);
      check_eq("c3_rst_busy", {31'd0, busy}, 32'd0);
      check_eq("c3_rst_ready", {31'd0, din_ready}, 32'd1);
      bad_valid = 0; bad_fd = 0;
      for (int i = 0; i < 12; i++) begin
         if (w_valid) bad_valid++;
         if (frame_done) bad_fd++;
         step();
      end
      check_eq("c3_no_valid_after", bad_valid, 32'd0);
      check_eq("c3_no_fd_after", bad_fd, 32'd0);

      // IDLE_BIT = 1 instance never saw traffic
      check_eq("idle1_w", {31'd0, w_i}, 32'd1);
      check_eq("idle1_valid", {31'd0, w_valid_i}, 32'd0);
      check_eq("idle1_busy", {31'd0, busy_i}, 32'd0);
      check_eq("idle1_ready", {31'd0, din_ready_i}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
